// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle between requesters and the add controller.
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, busy
    );
endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice: {cout, sum} = a + b + cin.
module nibble_add_slice
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);
    // Full nibble add including carry-in
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences one shared 4-bit adder slice across NIBBLES nibbles, LSB first,
// holding the inter-nibble carry and waiting SETTLE extra cycles per nibble.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned SETTLE  = 1
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int unsigned WIDTH = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = cnt_w(NIBBLES);
    localparam int unsigned CNT_W = cnt_w(SETTLE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // already inverted for subtract
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               in_ready_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;

    // {idx, 2'b00} keeps the bit offset wide enough for every nibble index
    assign a_nib = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign b_nib = b_q[{idx_q, 2'b00} +: NIBBLE_W];

    nibble_add_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q    <= bus.op_sub ? ~bus.op_cin : bus.op_cin;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= StAdd;
                    end
                end
                StAdd: begin
                    if (cnt_q == SETTLE_MAX) begin
                        result_q[{idx_q, 2'b00} +: NIBBLE_W] <= slice_sum;
                        carry_q <= slice_cout;
                        cnt_q   <= '0;
                        if (idx_q == LAST_IDX) begin
                            cout_q      <= slice_cout;
                            // b_q is B_eff, so this is true signed overflow for A-B too
                            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                           (slice_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at three parameter points.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus0 ();
    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus1 ();
    nibble_serial_add_ctrl_if #(.WIDTH(4))  bus2 ();

    nibble_serial_add_ctrl #(.NIBBLES(4), .SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    nibble_serial_add_ctrl #(.NIBBLES(4), .SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    nibble_serial_add_ctrl #(.NIBBLES(1), .SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic        busy;
        logic        cout;
        logic        overflow;
        logic [15:0] result;
    } obs_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference arithmetic at width 4*nib
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input int nib);
        exp_t        r;
        int          w;
        logic [16:0] m;
        logic [16:0] s;
        logic [15:0] beff;
        logic        c;
        w    = 4 * nib;
        m    = (17'd1 << w) - 17'd1;
        beff = sub ? ~b : b;
        c    = sub ? ~cin : cin;
        s    = ({1'b0, a} & m) + ({1'b0, beff} & m) + {16'd0, c};
        r.cout = s[w];
        r.res  = s[15:0] & m[15:0];
        r.ovf  = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
        return r;
    endfunction

    function automatic obs_t peek(input int sel);
        obs_t o;
        case (sel)
            0: o = '{bus0.in_ready, bus0.out_valid, bus0.busy, bus0.cout, bus0.overflow,
                     bus0.result};
            1: o = '{bus1.in_ready, bus1.out_valid, bus1.busy, bus1.cout, bus1.overflow,
                     bus1.result};
            default: o = '{bus2.in_ready, bus2.out_valid, bus2.busy, bus2.cout,
                           bus2.overflow, {12'd0, bus2.result}};
        endcase
        return o;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic sub);
        case (sel)
            0: begin bus0.in_valid = v; bus0.op_a = a; bus0.op_b = b;
                     bus0.op_cin = cin; bus0.op_sub = sub; end
            1: begin bus1.in_valid = v; bus1.op_a = a; bus1.op_b = b;
                     bus1.op_cin = cin; bus1.op_sub = sub; end
            default: begin bus2.in_valid = v; bus2.op_a = a[3:0]; bus2.op_b = b[3:0];
                           bus2.op_cin = cin; bus2.op_sub = sub; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: bus0.out_ready = v;
            1: bus1.out_ready = v;
            default: bus2.out_ready = v;
        endcase
    endtask

    // Drive one accepted request and push its expectation; returns at the negedge after accept
    task automatic send(input int sel, input int nib, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input logic sub);
        @(negedge clk);
        set_in(sel, 1'b1, a, b, cin, sub);
        sb.push_back(model(a, b, cin, sub, nib));
        @(negedge clk);
        set_in(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Wait for out_valid (bounded), capture outputs, then complete the output handshake
    task automatic collect(input int sel, output obs_t o, output int lat, output bit to,
                           output bit rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        o        = peek(sel);
        while (!o.out_valid && lat < 100) begin
            if (o.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
            o = peek(sel);
        end
        to = !o.out_valid;
        set_ordy(sel, 1'b1);
        @(negedge clk);
        set_ordy(sel, 1'b0);
    endtask

    task automatic test_reset();
        obs_t o;
        for (int s = 0; s < 3; s++) begin
            o = peek(s);
            checks++;
            if (o.in_ready !== 1'b1 || o.out_valid !== 1'b0 || o.busy !== 1'b0 ||
                o.result !== 16'h0 || o.cout !== 1'b0 || o.overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got rdy=%b ov=%b busy=%b res=%h c=%b o=%b",
                         s, o.in_ready, o.out_valid, o.busy, o.result, o.cout, o.overflow);
            end
        end
    endtask

    // Cases: basic add, carry chain, signed overflow, subtract variants
    task automatic test_add_sub();
        logic [15:0] ta[6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010};
        logic [15:0] tb[6] = '{16'h1111, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
        logic        tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] er[6] = '{16'h2345, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h000C};
        obs_t o;
        exp_t e;
        int   lat;
        bit   to;
        bit   rs;
        for (int i = 0; i < 6; i++) begin
            send(0, 4, ta[i], tb[i], tc[i], ts[i]);
            collect(0, o, lat, to, rs);
            e = sb.pop_front();
            checks++;
            if (to || lat != 8) begin
                errors++;
                $display("FAIL add_latency case%0d got %0d (timeout=%0b) want 8", i, lat, to);
            end
            checks++;
            if (o.result !== e.res || o.result !== er[i]) begin
                errors++;
                $display("FAIL add_result case%0d got %h want %h", i, o.result, er[i]);
            end
            checks++;
            if (o.cout !== e.cout || o.overflow !== e.ovf) begin
                errors++;
                $display("FAIL add_flags case%0d got c=%b o=%b want c=%b o=%b",
                         i, o.cout, o.overflow, e.cout, e.ovf);
            end
            checks++;
            if (rs !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_busy case%0d got 1 want 0", i);
            end
            o = peek(0);
            checks++;
            if (o.in_ready !== 1'b1 || o.out_valid !== 1'b0 || o.busy !== 1'b0) begin
                errors++;
                $display("FAIL back_to_idle case%0d got rdy=%b ov=%b busy=%b want 1 0 0",
                         i, o.in_ready, o.out_valid, o.busy);
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        obs_t snap;
        exp_t e;
        int   lat;
        bit   to;
        bit   rs;
        send(0, 4, 16'hA5C3, 16'h1234, 1'b1, 1'b0);
        lat  = 0;
        snap = peek(0);
        while (!snap.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            snap = peek(0);
        end
        checks++;
        if (!snap.out_valid) begin
            errors++;
            $display("FAIL bp_reach_done got timeout want out_valid");
        end
        for (int k = 0; k < 10; k++) begin
            set_in(0, k[0], 16'h0F0F, 16'h0F0F, 1'b0, 1'b0);
            @(negedge clk);
            o = peek(0);
            checks++;
            if (o.out_valid !== 1'b1 || o.result !== snap.result || o.cout !== snap.cout ||
                o.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got ov=%b res=%h c=%b rdy=%b want 1 %h %b 0",
                         k, o.out_valid, o.result, o.cout, o.in_ready, snap.result,
                         snap.cout);
            end
        end
        set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        collect(0, o, lat, to, rs);
        e = sb.pop_front();
        checks++;
        if (to || o.result !== e.res || o.cout !== e.cout || o.overflow !== e.ovf) begin
            errors++;
            $display("FAIL bp_result got %h c=%b o=%b want %h c=%b o=%b",
                     o.result, o.cout, o.overflow, e.res, e.cout, e.ovf);
        end
        o = peek(0);
        checks++;
        if (o.in_ready !== 1'b1 || o.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b ov=%b want 1 0", o.in_ready, o.out_valid);
        end
        repeat (12) @(negedge clk);
        o = peek(0);
        checks++;
        if (o.out_valid !== 1'b0 || o.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_not_queued got ov=%b busy=%b want 0 0", o.out_valid, o.busy);
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        exp_t e;
        int   lat;
        bit   to;
        bit   rs;
        send(0, 4, 16'h1234, 16'h5678, 1'b0, 1'b0);
        // After 4 more edges nibbles 0 and 1 are written; now inside nibble 2
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        o = peek(0);
        checks++;
        if (o.out_valid !== 1'b0 || o.result !== 16'h0 || o.cout !== 1'b0 ||
            o.overflow !== 1'b0 || o.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got ov=%b res=%h c=%b o=%b busy=%b want all 0",
                     o.out_valid, o.result, o.cout, o.overflow, o.busy);
        end
        void'(sb.pop_front());  // discarded in-flight op
        @(negedge clk);
        rst = 1'b0;
        send(0, 4, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        collect(0, o, lat, to, rs);
        e = sb.pop_front();
        checks++;
        if (to || lat != 8 || o.result !== 16'h0100 || o.result !== e.res ||
            o.cout !== e.cout) begin
            errors++;
            $display("FAIL post_reset_add got %h c=%b lat=%0d want 0100 c=%b lat=8",
                     o.result, o.cout, lat, e.cout);
        end
    endtask

    // Other parameter points: sel 1 (SETTLE=0), sel 2 (NIBBLES=1, SETTLE=3)
    task automatic test_params();
        logic [15:0] ta[3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [15:0] tb[3] = '{16'h1111, 16'h0001, 16'h0001};
        logic [15:0] na[3] = '{16'h4, 16'hF, 16'h7};
        logic [15:0] nb[3] = '{16'h1, 16'h1, 16'h1};
        obs_t o;
        exp_t e;
        int   lat;
        bit   to;
        bit   rs;
        for (int s = 1; s < 3; s++) begin
            for (int i = 0; i < 3; i++) begin
                if (s == 1) send(1, 4, ta[i], tb[i], 1'b0, 1'b0);
                else        send(2, 1, na[i], nb[i], 1'b0, 1'b0);
                collect(s, o, lat, to, rs);
                e = sb.pop_front();
                checks++;
                if (to || lat != 4) begin
                    errors++;
                    $display("FAIL param_latency dut%0d case%0d got %0d want 4", s, i, lat);
                end
                checks++;
                if (o.result !== e.res || o.cout !== e.cout || o.overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL param_result dut%0d case%0d got %h c=%b o=%b want %h c=%b o=%b",
                             s, i, o.result, o.cout, o.overflow, e.res, e.cout, e.ovf);
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            set_ordy(s, 1'b0);
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_add_sub();
        test_backpressure();
        test_async_reset();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
